cm_window_sequencer: RTL and testbench
======================================

Name: cm_window_sequencer

Overview:
Upstream control stage for the serial convolution MAC (CM_Serial). It buffers one N_TAPS-pixel window from an input stream and then issues pixel/weight pairs, one per cycle, on the MAC a/b inputs. It drives mux_reset to clear the accumulator on the first tap. It captures the MAC output once the last tap has propagated and presents it on a valid/ready result port.

Parameters:
N_TAPS, 9, taps per window; legal range 2..16.
PE_LAT, 1, cycles from a tap being presented on a_out/b_out to its contribution appearing on conv_in; legal range 1..4.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
w_wr_en  input  1  weight write strobe
w_addr  input  4  weight index, 0..N_TAPS-1; writes to larger indices are ignored
w_data  input  8  weight value
w_busy  output  1  high in STREAM/DRAIN; weight writes are ignored while high
px_valid  input  1  pixel stream valid
px_data  input  8  pixel value
px_ready  output  1  high only in FILL
a_out  output  8  pixel to MAC input a
b_out  output  8  weight to MAC input b
mux_reset  output  1  to MAC mux select; 1 feeds a zero partial sum
conv_in  input  8  MAC output (CM_Serial out)
res_valid  output  1  result available
res_data  output  8  captured convolution result
res_ready  input  1  result consumer ready

Behaviour:
- Reset (rst=0 at a clock edge), applied in any state:
  - state returns to IDLE; tap index, drain counter and pixel count clear.
  - a_out=0, b_out=0, mux_reset=1, px_ready=0, res_valid=0, res_data=0, w_busy=0.
  - Weight registers are also cleared to 0.
- The weight register file holds N_TAPS x 8 bits.
  - A write takes effect at the clock edge when w_wr_en=1, w_busy=0 and w_addr<N_TAPS.
  - A weight written in the same cycle as the IDLE->FILL transition is used by that window.
- FSM:
  - IDLE: px_ready=0. Moves to FILL on the next cycle unconditionally.
  - FILL: px_ready=1. Each cycle with px_valid=1, px_data is stored at pix[cnt] and cnt increments. When the N_TAPS-th pixel is accepted, go to STREAM and clear the tap index.
  - STREAM: lasts exactly N_TAPS cycles, k=0..N_TAPS-1.
    - a_out=pix[k] and b_out=w[k], both registered outputs valid in the cycle they are presented.
    - mux_reset=1 at k=0 and 0 for k>0.
    - After k=N_TAPS-1, go to DRAIN.
  - DRAIN: a_out=0, b_out=0, mux_reset=0, held for PE_LAT-1 cycles, then one capture cycle.
    - On the capture cycle, conv_in is registered into res_data, res_valid goes to 1, and the state moves to DONE.
    - The capture cycle is the PE_LAT-th cycle after the last tap was presented.
    - For PE_LAT=1, DRAIN is a single capture cycle.
  - DONE: res_valid=1 and res_data stable until the cycle res_ready=1. On that cycle res_valid drops on the next edge and the state goes to FILL.
- Outputs outside STREAM/DRAIN: a_out=0, b_out=0, mux_reset=1, so the MAC accumulator settles to 0.
- Arithmetic: no arithmetic in this block. The result is the MAC's 8-bit modulo-256 sum of products, captured unchanged.
- Pixel acceptance: no pixel is accepted outside FILL, and px_data is ignored when px_ready=0.
- Back-to-back windows: the next FILL starts the cycle after the res_ready handshake, so there is no overlap.
- Stalls in FILL: px_valid gaps pause filling with no timeout. cnt is held.
- res_ready=1 outside DONE has no effect.

Test Plan:
1. N_TAPS=9, PE_LAT=1, write w[0..8]=1, stream pixels 1..9 back-to-back, res_ready=1 -> mux_reset=1 only on the first STREAM cycle; res_valid=1 on the second cycle after the last tap is presented; res_data=45 (0x2D).
2. Weights all 2, pixels all 20 -> res_data=360 mod 256=104 (0x68), checking wrap-around.
3. Same as test 1 with res_ready held low for 5 cycles after res_valid -> res_valid and res_data=45 stay stable for 5 cycles; px_ready=0 throughout; FILL starts the cycle after res_ready=1.
4. Write w[3]=7 on a cycle where w_busy=1 -> the weight is unchanged and the result matches the pre-write weights; write w[12]=5 -> ignored.
5. Assert rst=0 at STREAM tap k=4 -> on the next cycle state=IDLE, mux_reset=1, a_out=b_out=0, res_valid=0, all weights=0; a following full window with weights reloaded gives the correct result.
6. Pixel stream with px_valid toggling 1,0,1,0 -> only valid beats are stored; STREAM order is pix[0..8] in arrival order and the result equals the expected dot product.

Source files
------------

// File: rtl/cm_window_sequencer.sv
// Window sequencer for the serial convolution MAC: buffers N_TAPS pixels, streams
// pixel/weight pairs to the MAC, then captures the MAC sum on a valid/ready port.
module cm_window_sequencer #(
    parameter int N_TAPS = 9,
    parameter int PE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       w_wr_en,
    input  logic [3:0] w_addr,
    input  logic [7:0] w_data,
    output logic       w_busy,
    input  logic       px_valid,
    input  logic [7:0] px_data,
    output logic       px_ready,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic       mux_reset,
    input  logic [7:0] conv_in,
    output logic       res_valid,
    output logic [7:0] res_data,
    input  logic       res_ready
);
    localparam int CW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [CW-1:0] LAST_TAP   = CW'(N_TAPS - 1);
    localparam logic [1:0]    DRAIN_LAST = 2'(PE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_tap;
    logic [1:0]    r_drain;
    logic [7:0]    r_pix [N_TAPS];
    logic [7:0]    r_w   [N_TAPS];
    logic [7:0]    r_a;
    logic [7:0]    r_b;
    logic          r_mux;
    logic          r_px_ready;
    logic          r_res_valid;
    logic [7:0]    r_res_data;
    logic          r_w_busy;

    logic          w_wr_ok;
    logic [CW-1:0] w_wr_idx;
    logic [CW-1:0] w_tap_nxt;
    logic [7:0]    w_first_w;

    assign w_wr_ok   = w_wr_en && !r_w_busy && ({1'b0, w_addr} < 5'(N_TAPS));
    assign w_wr_idx  = w_addr[CW-1:0];
    assign w_tap_nxt = r_tap + CW'(1);
    // A write to tap 0 landing on the FILL->STREAM edge must reach the first tap.
    assign w_first_w = (w_wr_ok && (w_wr_idx == {CW{1'b0}})) ? w_data : r_w[0];

    // Weight register file; writes are blocked while a window is in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                r_w[i] <= 8'd0;
            end
        end else if (w_wr_ok) begin
            r_w[w_wr_idx] <= w_data;
        end
    end

    // Window FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_tap       <= {CW{1'b0}};
            r_drain     <= 2'd0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_mux       <= 1'b1;
            r_px_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 8'd0;
            r_w_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FILL;
                    r_cnt      <= {CW{1'b0}};
                    r_px_ready <= 1'b1;
                end
                S_FILL: begin
                    if (px_valid) begin
                        r_pix[r_cnt] <= px_data;
                        if (r_cnt == LAST_TAP) begin
                            r_state    <= S_STREAM;
                            r_cnt      <= {CW{1'b0}};
                            r_tap      <= {CW{1'b0}};
                            r_a        <= r_pix[0];
                            r_b        <= w_first_w;
                            r_mux      <= 1'b1;
                            r_px_ready <= 1'b0;
                            r_w_busy   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_STREAM: begin
                    if (r_tap == LAST_TAP) begin
                        r_state <= S_DRAIN;
                        r_drain <= 2'd0;
                        r_a     <= 8'd0;
                        r_b     <= 8'd0;
                        r_mux   <= 1'b0;
                    end else begin
                        r_tap <= w_tap_nxt;
                        r_a   <= r_pix[w_tap_nxt];
                        r_b   <= r_w[w_tap_nxt];
                        r_mux <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state     <= S_DONE;
                        r_res_data  <= conv_in;
                        r_res_valid <= 1'b1;
                        r_mux       <= 1'b1;
                        r_w_busy    <= 1'b0;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state     <= S_FILL;
                        r_res_valid <= 1'b0;
                        r_px_ready  <= 1'b1;
                        r_cnt       <= {CW{1'b0}};
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_a         <= 8'd0;
                    r_b         <= 8'd0;
                    r_mux       <= 1'b1;
                    r_px_ready  <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_w_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign w_busy    = r_w_busy;
    assign px_ready  = r_px_ready;
    assign a_out     = r_a;
    assign b_out     = r_b;
    assign mux_reset = r_mux;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_cm_window_sequencer.sv
// Self-checking bench for cm_window_sequencer with a behavioural MAC in the loop
// and a dot-product reference model.
module tb_cm_window_sequencer;
    localparam int N   = 9;
    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_wr_en = 1'b0;
    logic [3:0] w_addr = 4'd0;
    logic [7:0] w_data = 8'd0;
    logic       w_busy;
    logic       px_valid = 1'b0;
    logic [7:0] px_data = 8'd0;
    logic       px_ready;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic       mux_reset;
    logic [7:0] conv_in;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready = 1'b0;

    logic [7:0] mac_acc = 8'd0;
    int         errors = 0;
    int         checks = 0;

    logic [7:0] mdl_w  [N];
    logic [7:0] pix_in [N];
    logic [7:0] obs_a  [N];
    logic [7:0] obs_b  [N];
    logic       obs_mux [N];
    logic       obs_busy [N];
    logic       obs_pxr [N];
    logic [7:0] drain_ab;
    logic       drain_mux;
    int         lat;
    bit         timed_out;

    cm_window_sequencer #(.N_TAPS(N), .PE_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data), .w_busy(w_busy),
        .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
        .a_out(a_out), .b_out(b_out), .mux_reset(mux_reset),
        .conv_in(conv_in), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // Serial MAC with one cycle of latency: mux_reset feeds a zero partial sum.
    always @(posedge clk) mac_acc <= (mux_reset ? 8'd0 : mac_acc) + a_out * b_out;
    assign conv_in = mac_acc;

    function automatic logic [7:0] ref_dot();
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(mdl_w[k]) * int'(pix_in[k]);
        return 8'(s % 256);
    endfunction

    function automatic int stream_diff();
        int bad = 0;
        for (int k = 0; k < N; k++) begin
            if (obs_a[k] !== pix_in[k] || obs_b[k] !== mdl_w[k] ||
                obs_mux[k] !== (k == 0) || obs_busy[k] !== 1'b1 || obs_pxr[k] !== 1'b0)
                bad++;
        end
        return bad;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_weight(input logic [3:0] addr, input logic [7:0] data, input bit accepted);
        w_wr_en = 1'b1; w_addr = addr; w_data = data;
        cycle();
        w_wr_en = 1'b0;
        if (accepted && addr < 4'(N)) mdl_w[addr] = data;
    endtask

    task automatic load_all(input int mode);
        for (int k = 0; k < N; k++)
            write_weight(4'(k), (mode == 0) ? 8'd1 : (mode == 1) ? 8'd2 : 8'($urandom), 1'b1);
    endtask

    // Feeds pix_in through the handshake, records the STREAM/DRAIN outputs and the
    // number of cycles from the last tap to res_valid.
    task automatic run_window(input int mode, input int inject_tap, input int rst_tap, output bit aborted);
        int i = 0;
        int cyc = 0;
        bit v, rdy;
        aborted = 1'b0; timed_out = 1'b0;
        while (i < N && cyc < 400) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            px_valid = v;
            px_data = v ? pix_in[i] : 8'($urandom);
            rdy = px_ready;
            cycle();
            cyc++;
            if (v && rdy) i++;
        end
        px_valid = 1'b0;
        if (i < N) begin timed_out = 1'b1; return; end
        for (int k = 0; k < N; k++) begin
            obs_a[k] = a_out; obs_b[k] = b_out; obs_mux[k] = mux_reset;
            obs_busy[k] = w_busy; obs_pxr[k] = px_ready;
            if (k == rst_tap) begin
                rst = 1'b0;
                cycle();
                rst = 1'b1;
                aborted = 1'b1;
                return;
            end
            if (k == inject_tap) begin w_wr_en = 1'b1; w_addr = 4'd3; w_data = 8'd7; end
            cycle();
            w_wr_en = 1'b0;
        end
        drain_ab = a_out | b_out;
        drain_mux = mux_reset;
        lat = 1;
        while (!res_valid && lat < 20) begin cycle(); lat++; end
        if (res_valid !== 1'b1) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) cycle();
        checks++;
        if (a_out !== 8'd0 || b_out !== 8'd0 || mux_reset !== 1'b1) begin
            errors++; $display("FAIL reset_mac_outs: a=%0d b=%0d mux=%0b, want 0 0 1", a_out, b_out, mux_reset);
        end
        checks++;
        if (px_ready !== 1'b0 || w_busy !== 1'b0) begin
            errors++; $display("FAIL reset_ready_busy: px_ready=%0b w_busy=%0b, want 0 0", px_ready, w_busy);
        end
        checks++;
        if (res_valid !== 1'b0 || res_data !== 8'd0) begin
            errors++; $display("FAIL reset_result: valid=%0b data=%0d, want 0 0", res_valid, res_data);
        end
        for (int k = 0; k < N; k++) mdl_w[k] = 8'd0;
        rst = 1'b1;
        cycle();
        checks++;
        if (px_ready !== 1'b1) begin
            errors++; $display("FAIL idle_to_fill: px_ready=%0b, want 1", px_ready);
        end
    endtask

    task automatic test_basic();
        bit ab;
        load_all(0);
        for (int k = 0; k < N; k++) pix_in[k] = 8'(k + 1);
        res_ready = 1'b1;
        run_window(0, -1, -1, ab);
        checks++;
        if (timed_out) begin errors++; $display("FAIL basic_timeout: no result, want res_valid"); end
        checks++;
        if (stream_diff() !== 0) begin
            errors++; $display("FAIL basic_stream: %0d taps wrong, want 0", stream_diff());
        end
        checks++;
        if (drain_ab !== 8'd0 || drain_mux !== 1'b0) begin
            errors++; $display("FAIL basic_drain: a|b=%0d mux=%0b, want 0 0", drain_ab, drain_mux);
        end
        checks++;
        if (lat !== LAT + 1) begin errors++; $display("FAIL basic_latency: %0d, want %0d", lat, LAT + 1); end
        checks++;
        if (res_data !== 8'd45) begin errors++; $display("FAIL basic_result: %0d, want 45", res_data); end
        cycle();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || px_ready !== 1'b1) begin
            errors++; $display("FAIL basic_handshake: valid=%0b px_ready=%0b, want 0 1", res_valid, px_ready);
        end
    endtask

    task automatic test_wrap();
        bit ab;
        load_all(1);
        for (int k = 0; k < N; k++) pix_in[k] = 8'd20;
        res_ready = 1'b1;
        run_window(0, -1, -1, ab);
        checks++;
        if (timed_out || res_data !== 8'd104) begin
            errors++; $display("FAIL wrap_result: %0d (timeout=%0b), want 104", res_data, timed_out);
        end
        cycle();
        res_ready = 1'b0;
    endtask

    task automatic test_result_stall();
        bit ab;
        int bad = 0;
        load_all(0);
        for (int k = 0; k < N; k++) pix_in[k] = 8'(k + 1);
        run_window(0, -1, -1, ab);
        for (int c = 0; c < 5; c++) begin
            if (res_valid !== 1'b1 || res_data !== 8'd45 || px_ready !== 1'b0) bad++;
            cycle();
        end
        checks++;
        if (timed_out || bad !== 0) begin
            errors++; $display("FAIL stall_hold: %0d unstable cycles (timeout=%0b), want 0", bad, timed_out);
        end
        res_ready = 1'b1;
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_before_ready: valid=%0b, want 1", res_valid); end
        cycle();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || px_ready !== 1'b1) begin
            errors++; $display("FAIL stall_handshake: valid=%0b px_ready=%0b, want 0 1", res_valid, px_ready);
        end
    endtask

    task automatic test_busy_write();
        bit ab;
        load_all(2);
        write_weight(4'd3, 8'd11, 1'b1);
        write_weight(4'd12, 8'd5, 1'b1);
        for (int k = 0; k < N; k++) pix_in[k] = 8'($urandom);
        res_ready = 1'b1;
        run_window(0, 4, -1, ab);
        checks++;
        if (timed_out || res_data !== ref_dot()) begin
            errors++; $display("FAIL busy_result: %0d, want %0d", res_data, ref_dot());
        end
        cycle();
        for (int k = 0; k < N; k++) pix_in[k] = 8'($urandom);
        run_window(0, -1, -1, ab);
        checks++;
        if (timed_out || stream_diff() !== 0 || res_data !== ref_dot()) begin
            errors++; $display("FAIL busy_next_window: result %0d diff %0d, want %0d diff 0", res_data, stream_diff(), ref_dot());
        end
        cycle();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ab;
        load_all(2);
        for (int k = 0; k < N; k++) pix_in[k] = 8'($urandom);
        run_window(0, -1, 4, ab);
        checks++;
        if (!ab || a_out !== 8'd0 || b_out !== 8'd0 || mux_reset !== 1'b1 || res_valid !== 1'b0 ||
            px_ready !== 1'b0 || w_busy !== 1'b0) begin
            errors++; $display("FAIL midreset_outs: a=%0d b=%0d mux=%0b valid=%0b rdy=%0b busy=%0b, want 0 0 1 0 0 0",
                               a_out, b_out, mux_reset, res_valid, px_ready, w_busy);
        end
        for (int k = 0; k < N; k++) mdl_w[k] = 8'd0;
        write_weight(4'd0, 8'($urandom_range(1, 255)), 1'b1);
        for (int k = 0; k < N; k++) pix_in[k] = 8'($urandom);
        res_ready = 1'b1;
        run_window(0, -1, -1, ab);
        checks++;
        if (timed_out || stream_diff() !== 0 || res_data !== ref_dot()) begin
            errors++; $display("FAIL midreset_cleared: result %0d diff %0d, want %0d diff 0", res_data, stream_diff(), ref_dot());
        end
        cycle();
        load_all(2);
        run_window(0, -1, -1, ab);
        checks++;
        if (timed_out || res_data !== ref_dot()) begin
            errors++; $display("FAIL midreset_reload: %0d, want %0d", res_data, ref_dot());
        end
        cycle();
        res_ready = 1'b0;
    endtask

    task automatic test_px_gaps();
        bit ab;
        load_all(2);
        for (int k = 0; k < N; k++) pix_in[k] = 8'($urandom);
        res_ready = 1'b1;
        run_window(1, -1, -1, ab);
        checks++;
        if (timed_out || stream_diff() !== 0 || res_data !== ref_dot()) begin
            errors++; $display("FAIL gaps_result: %0d diff %0d, want %0d diff 0", res_data, stream_diff(), ref_dot());
        end
        cycle();
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ab;
        int d;
        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(0, 5)) write_weight(4'($urandom_range(0, 15)), 8'($urandom), 1'b1);
            for (int k = 0; k < N; k++) pix_in[k] = 8'($urandom);
            run_window(2, -1, -1, ab);
            checks++;
            if (timed_out || stream_diff() !== 0 || res_data !== ref_dot()) begin
                errors++; $display("FAIL b2b_result[%0d]: %0d diff %0d, want %0d diff 0", it, res_data, stream_diff(), ref_dot());
            end
            d = $urandom_range(0, 3);
            repeat (d) cycle();
            res_ready = 1'b1;
            cycle();
            res_ready = 1'b0;
            checks++;
            if (res_valid !== 1'b0 || px_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_handshake[%0d]: valid=%0b px_ready=%0b, want 0 1", it, res_valid, px_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_result_stall();
        test_busy_write();
        test_reset_mid();
        test_px_gaps();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
